// File: rtl/arp_reply_learner_pkg.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_learner_pkg
// Brief    : Shared constants, state encodings and helpers for the ARP learner.
// Revision : 1.0 - initial release
// ============================================================================
package arp_reply_learner_pkg;

    localparam logic [15:0] ARP_ETHERTYPE  = 16'h0806;
    localparam logic [15:0] ARP_HTYPE_ETH  = 16'h0001;
    localparam logic [15:0] ARP_PTYPE_IPV4 = 16'h0800;
    localparam logic [7:0]  ARP_HLEN_ETH   = 8'd6;
    localparam logic [7:0]  ARP_PLEN_IPV4  = 8'd4;
    localparam logic [15:0] ARP_OP_REPLY   = 16'h0002;

    typedef enum logic [2:0] {
        HDR      = 3'd0,
        W1       = 3'd1,
        W2       = 3'd2,
        W3       = 3'd3,
        WAIT_EOP = 3'd4
    } parser_state_t;

    typedef enum logic [0:0] {
        W_IDLE = 1'b0,
        W_REQ  = 1'b1
    } writer_state_t;

    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/arp_reply_learner_if.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_learner_if
// Brief    : Snooped datapath plus ARP table write port.
// Revision : 1.0 - initial release
// ============================================================================
interface arp_reply_learner_if #(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = 8,
    parameter int LUT_DEPTH_BITS = 5
);
    logic [DATA_WIDTH-1:0]     in_data;
    logic [CTRL_WIDTH-1:0]     in_ctrl;
    logic                      in_wr;
    logic [LUT_DEPTH_BITS-1:0] arp_wr_addr;
    logic                      arp_wr_req;
    logic [47:0]               arp_wr_mac;
    logic [31:0]               arp_wr_ip;
    logic                      arp_wr_ack;

    modport master (
        output in_data, in_ctrl, in_wr, arp_wr_ack,
        input  arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip
    );

    modport slave (
        input  in_data, in_ctrl, in_wr, arp_wr_ack,
        output arp_wr_addr, arp_wr_req, arp_wr_mac, arp_wr_ip
    );
endinterface
`default_nettype wire

// File: rtl/arp_reply_learner_parser.sv
`default_nettype none
// ============================================================================
// Module   : arp_pkt_parser
// Brief    : Tracks packet words, checks ARP reply fields, pulses on a valid w3.
// Revision : 1.0 - initial release
// ============================================================================
module arp_pkt_parser
    import arp_reply_learner_pkg::*;
#(
    parameter int DATA_WIDTH = 64,
    parameter int CTRL_WIDTH = 8
) (
    input  wire logic                  clk,
    input  wire logic                  reset,
    input  wire logic [DATA_WIDTH-1:0] i_data,
    input  wire logic [CTRL_WIDTH-1:0] i_ctrl,
    input  wire logic                  i_wr,
    input  wire logic                  i_learn_en,
    output logic                       o_reply_vld,
    output logic [47:0]                o_reply_sha,
    output logic [31:0]                o_reply_spa
);

    parser_state_t state_q, state_d;
    logic          w1_ok_q, w1_ok_d;
    logic          w2_ok_q, w2_ok_d;
    logic [15:0]   sha_hi_q, sha_hi_d;
    logic          w_ctrl_word;

    assign w_ctrl_word = (i_ctrl != '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= HDR;
            w1_ok_q  <= 1'b0;
            w2_ok_q  <= 1'b0;
            sha_hi_q <= 16'h0000;
        end else begin
            state_q  <= state_d;
            w1_ok_q  <= w1_ok_d;
            w2_ok_q  <= w2_ok_d;
            sha_hi_q <= sha_hi_d;
        end
    end

    always_comb begin
        state_d     = state_q;
        w1_ok_d     = w1_ok_q;
        w2_ok_d     = w2_ok_q;
        sha_hi_d    = sha_hi_q;
        o_reply_vld = 1'b0;
        o_reply_sha = {sha_hi_q, i_data[63:32]};
        o_reply_spa = i_data[31:0];
        if (i_wr) begin
            case (state_q)
                HDR: begin
                    if (!w_ctrl_word) state_d = W1;
                end
                W1: begin
                    if (w_ctrl_word) begin
                        state_d = HDR;
                    end else begin
                        w1_ok_d = (i_data[31:16] == ARP_ETHERTYPE) &&
                                  (i_data[15:0]  == ARP_HTYPE_ETH);
                        state_d = W2;
                    end
                end
                W2: begin
                    if (w_ctrl_word) begin
                        state_d = HDR;
                    end else begin
                        w2_ok_d  = (i_data[63:48] == ARP_PTYPE_IPV4) &&
                                   (i_data[47:40] == ARP_HLEN_ETH)   &&
                                   (i_data[39:32] == ARP_PLEN_IPV4)  &&
                                   (i_data[31:16] == ARP_OP_REPLY);
                        sha_hi_d = i_data[15:0];
                        state_d  = W3;
                    end
                end
                W3: begin
                    if (w_ctrl_word) begin
                        state_d = HDR;
                    end else begin
                        // sha_hi_q[8] is SHA bit 40, the multicast flag
                        o_reply_vld = w1_ok_q && w2_ok_q && i_learn_en &&
                                      (i_data[31:0] != 32'h0) && !sha_hi_q[8];
                        state_d     = WAIT_EOP;
                    end
                end
                WAIT_EOP: begin
                    if (w_ctrl_word) state_d = HDR;
                end
                default: state_d = HDR;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/arp_reply_learner.sv
`default_nettype none
// ============================================================================
// Module   : arp_reply_learner
// Brief    : Learns sender bindings from ARP replies into the ARP table.
// Revision : 1.0 - initial release
// ============================================================================
module arp_reply_learner
    import arp_reply_learner_pkg::*;
#(
    parameter int DATA_WIDTH     = 64,
    parameter int CTRL_WIDTH     = 8,
    parameter int LUT_DEPTH      = 32,
    parameter int LUT_DEPTH_BITS = $clog2(LUT_DEPTH),
    parameter int LEARN_BASE     = 16
) (
    input  wire logic         clk,
    input  wire logic         reset,
    arp_reply_learner_if.slave bus,
    input  wire logic         learn_en,
    output logic [31:0]       num_learned,
    output logic [31:0]       num_dropped
);

    localparam logic [LUT_DEPTH_BITS-1:0] C_BASE = LUT_DEPTH_BITS'(LEARN_BASE);
    localparam logic [LUT_DEPTH_BITS-1:0] C_LAST = LUT_DEPTH_BITS'(LUT_DEPTH - 1);

    logic        w_reply_vld;
    logic [47:0] w_reply_sha;
    logic [31:0] w_reply_spa;

    arp_pkt_parser #(
        .DATA_WIDTH (DATA_WIDTH),
        .CTRL_WIDTH (CTRL_WIDTH)
    ) u_parser (
        .clk         (clk),
        .reset       (reset),
        .i_data      (bus.in_data),
        .i_ctrl      (bus.in_ctrl),
        .i_wr        (bus.in_wr),
        .i_learn_en  (learn_en),
        .o_reply_vld (w_reply_vld),
        .o_reply_sha (w_reply_sha),
        .o_reply_spa (w_reply_spa)
    );

    writer_state_t             state_q, state_d;
    logic [LUT_DEPTH_BITS-1:0] addr_q, addr_d;
    logic                      req_q, req_d;
    logic [47:0]               mac_q, mac_d;
    logic [31:0]               ip_q, ip_d;
    logic [31:0]               learned_q, learned_d;
    logic [31:0]               dropped_q, dropped_d;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= W_IDLE;
            addr_q    <= C_BASE;
            req_q     <= 1'b0;
            mac_q     <= 48'h0;
            ip_q      <= 32'h0;
            learned_q <= 32'h0;
            dropped_q <= 32'h0;
        end else begin
            state_q   <= state_d;
            addr_q    <= addr_d;
            req_q     <= req_d;
            mac_q     <= mac_d;
            ip_q      <= ip_d;
            learned_q <= learned_d;
            dropped_q <= dropped_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        addr_d    = addr_q;
        req_d     = req_q;
        mac_d     = mac_q;
        ip_d      = ip_q;
        learned_d = learned_q;
        dropped_d = dropped_q;
        case (state_q)
            W_IDLE: begin
                if (w_reply_vld) begin
                    mac_d   = w_reply_sha;
                    ip_d    = w_reply_spa;
                    req_d   = 1'b1;
                    state_d = W_REQ;
                end
            end
            W_REQ: begin
                // A commit landing on the ack cycle still sees a busy writer
                if (w_reply_vld) dropped_d = sat_inc(dropped_q);
                if (bus.arp_wr_ack) begin
                    req_d     = 1'b0;
                    learned_d = sat_inc(learned_q);
                    addr_d    = (addr_q == C_LAST) ? C_BASE
                                                   : addr_q + LUT_DEPTH_BITS'(1);
                    state_d   = W_IDLE;
                end
            end
            default: state_d = W_IDLE;
        endcase
    end

    assign bus.arp_wr_addr = addr_q;
    assign bus.arp_wr_req  = req_q;
    assign bus.arp_wr_mac  = mac_q;
    assign bus.arp_wr_ip   = ip_q;
    assign num_learned     = learned_q;
    assign num_dropped     = dropped_q;

endmodule
`default_nettype wire

// File: tb/tb_arp_reply_learner.sv
`default_nettype none
// ============================================================================
// Module   : tb_arp_reply_learner
// Brief    : Self-checking bench with a frame-level reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_arp_reply_learner;

    localparam int DW   = 64;
    localparam int CW   = 8;
    localparam int LD   = 32;
    localparam int LDB  = 5;
    localparam int BASE = 16;

    typedef struct {
        logic [15:0] ethertype;
        logic [15:0] htype;
        logic [15:0] ptype;
        logic [7:0]  hlen;
        logic [7:0]  plen;
        logic [15:0] oper;
        logic [47:0] sha;
        logic [31:0] spa;
    } arp_fields_t;

    logic        clk = 1'b0;
    logic        reset;
    logic        learn_en;
    logic [31:0] num_learned;
    logic [31:0] num_dropped;

    int n_vec = 0;
    int n_err = 0;

    // Reference model state
    bit          m_pending;
    logic [47:0] m_mac;
    logic [31:0] m_ip;
    int          m_learned;
    int          m_dropped;

    arp_reply_learner_if #(.DATA_WIDTH(DW), .CTRL_WIDTH(CW), .LUT_DEPTH_BITS(LDB)) bus ();

    arp_reply_learner #(
        .DATA_WIDTH(DW), .CTRL_WIDTH(CW), .LUT_DEPTH(LD),
        .LUT_DEPTH_BITS(LDB), .LEARN_BASE(BASE)
    ) dut (
        .clk         (clk),
        .reset       (reset),
        .bus         (bus),
        .learn_en    (learn_en),
        .num_learned (num_learned),
        .num_dropped (num_dropped)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [LDB-1:0] exp_addr(input int learned);
        return LDB'(BASE + (learned % (LD - BASE)));
    endfunction

    function automatic arp_fields_t good_frame(input logic [47:0] sha, input logic [31:0] spa);
        arp_fields_t f;
        f.ethertype = 16'h0806; f.htype = 16'd1; f.ptype = 16'h0800;
        f.hlen = 8'd6; f.plen = 8'd4; f.oper = 16'd2;
        f.sha = sha; f.spa = spa;
        return f;
    endfunction

    function automatic bit is_valid_reply(input arp_fields_t f, input logic le);
        return f.ethertype == 16'h0806 && f.htype == 16'd1 && f.ptype == 16'h0800 &&
               f.hlen == 8'd6 && f.plen == 8'd4 && f.oper == 16'd2 &&
               f.spa != 32'd0 && f.sha[40] == 1'b0 && le == 1'b1;
    endfunction

    function automatic arp_fields_t rand_good();
        logic [47:0] sha;
        logic [31:0] spa;
        sha = {$urandom, $urandom} & ~(48'h1 << 40);
        spa = $urandom;
        if (spa == 32'd0) spa = 32'd1;
        return good_frame(sha, spa);
    endfunction

    // Word list: header, data words 0..3, EOP word. eop_word>=0 truncates at that data word.
    task automatic send_frame(input arp_fields_t f, input int max_gap, input int eop_word);
        logic [DW-1:0] words [5];
        words[0] = {$urandom, $urandom};
        words[1] = {$urandom, $urandom};
        words[2] = {$urandom, f.ethertype, f.htype};
        words[3] = {f.ptype, f.hlen, f.plen, f.oper, f.sha[47:32]};
        words[4] = {f.sha[31:0], f.spa};
        for (int i = 0; i < 6; i++) begin
            if (i > 0) begin
                bus.in_wr = 1'b0;
                repeat ($urandom_range(max_gap, 0)) tick();
            end
            bus.in_wr = 1'b1;
            if (i == 0) begin
                bus.in_data = words[0]; bus.in_ctrl = 8'hFF;
            end else if (i == 5) begin
                bus.in_data = {$urandom, $urandom}; bus.in_ctrl = 8'h01;
            end else begin
                bus.in_data = words[i];
                bus.in_ctrl = (eop_word == i - 1) ? 8'h01 : 8'h00;
            end
            tick();
            if (i > 0 && eop_word == i - 1) break;
        end
        bus.in_wr = 1'b0;
        if (eop_word < 0 && is_valid_reply(f, learn_en)) begin
            if (m_pending) m_dropped++;
            else begin
                m_pending = 1'b1; m_mac = f.sha; m_ip = f.spa;
            end
        end
    endtask

    task automatic pulse_ack();
        bus.arp_wr_ack = 1'b1;
        tick();
        bus.arp_wr_ack = 1'b0;
        if (m_pending) begin
            m_pending = 1'b0;
            m_learned++;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1; bus.in_wr = 1'b0; bus.arp_wr_ack = 1'b0;
        repeat (2) tick();
        reset = 1'b0;
        m_pending = 1'b0; m_learned = 0; m_dropped = 0;
        tick();
    endtask

    task automatic test_reset();
        do_reset();
        n_vec++; if (bus.arp_wr_req !== 1'b0) begin n_err++; $display("FAIL reset_req got %0b exp 0", bus.arp_wr_req); end
        n_vec++; if (bus.arp_wr_addr !== LDB'(BASE)) begin n_err++; $display("FAIL reset_addr got %0d exp %0d", bus.arp_wr_addr, BASE); end
        n_vec++; if (bus.arp_wr_mac !== 48'h0 || bus.arp_wr_ip !== 32'h0) begin n_err++; $display("FAIL reset_macip got %h/%h exp 0/0", bus.arp_wr_mac, bus.arp_wr_ip); end
        n_vec++; if (num_learned !== 32'd0 || num_dropped !== 32'd0) begin n_err++; $display("FAIL reset_cnt got %0d/%0d exp 0/0", num_learned, num_dropped); end
    endtask

    task automatic test_single(input int max_gap, input string tag);
        do_reset();
        learn_en = 1'b1;
        send_frame(good_frame(48'h001122334455, 32'h0A000001), max_gap, -1);
        n_vec++; if (bus.arp_wr_req !== 1'b1 || bus.arp_wr_addr !== 5'd16) begin n_err++; $display("FAIL %s_req got req=%0b addr=%0d exp 1/16", tag, bus.arp_wr_req, bus.arp_wr_addr); end
        n_vec++; if (bus.arp_wr_mac !== 48'h001122334455 || bus.arp_wr_ip !== 32'h0A000001) begin n_err++; $display("FAIL %s_data got %h/%h exp 001122334455/0a000001", tag, bus.arp_wr_mac, bus.arp_wr_ip); end
        repeat (3) tick();
        n_vec++; if (bus.arp_wr_req !== 1'b1) begin n_err++; $display("FAIL %s_hold got %0b exp 1", tag, bus.arp_wr_req); end
        pulse_ack();
        n_vec++; if (bus.arp_wr_req !== 1'b0 || num_learned !== 32'd1 || bus.arp_wr_addr !== 5'd17) begin n_err++; $display("FAIL %s_ack got req=%0b learned=%0d addr=%0d exp 0/1/17", tag, bus.arp_wr_req, num_learned, bus.arp_wr_addr); end
        pulse_ack();
        n_vec++; if (num_learned !== 32'd1 || bus.arp_wr_addr !== 5'd17) begin n_err++; $display("FAIL %s_idle_ack got learned=%0d addr=%0d exp 1/17", tag, num_learned, bus.arp_wr_addr); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        learn_en = 1'b1;
        for (int i = 0; i < 17; i++) begin
            send_frame(rand_good(), 0, -1);
            n_vec++; if (bus.arp_wr_req !== 1'b1 || bus.arp_wr_addr !== exp_addr(i) || bus.arp_wr_mac !== m_mac) begin n_err++; $display("FAIL b2b_%0d got req=%0b addr=%0d mac=%h exp 1/%0d/%h", i, bus.arp_wr_req, bus.arp_wr_addr, bus.arp_wr_mac, exp_addr(i), m_mac); end
            pulse_ack();
        end
        n_vec++; if (num_learned !== 32'd17 || bus.arp_wr_addr !== 5'd17) begin n_err++; $display("FAIL b2b_end got learned=%0d addr=%0d exp 17/17", num_learned, bus.arp_wr_addr); end
    endtask

    task automatic test_drop();
        arp_fields_t a;
        do_reset();
        learn_en = 1'b1;
        a = rand_good();
        send_frame(a, 1, -1);
        send_frame(rand_good(), 1, -1);
        n_vec++; if (num_dropped !== 32'd1 || bus.arp_wr_mac !== a.sha || bus.arp_wr_ip !== a.spa) begin n_err++; $display("FAIL drop got dropped=%0d mac=%h ip=%h exp 1/%h/%h", num_dropped, bus.arp_wr_mac, bus.arp_wr_ip, a.sha, a.spa); end
        pulse_ack();
        repeat (4) tick();
        n_vec++; if (bus.arp_wr_req !== 1'b0 || num_learned !== 32'd1) begin n_err++; $display("FAIL drop_after got req=%0b learned=%0d exp 0/1", bus.arp_wr_req, num_learned); end
    endtask

    task automatic test_nonmatch();
        arp_fields_t f [4];
        do_reset();
        learn_en = 1'b1;
        f[0] = rand_good(); f[0].oper = 16'd1;
        f[1] = rand_good(); f[1].ethertype = 16'h0800;
        f[2] = good_frame(48'h01005e000001, 32'h0A000002);
        f[3] = rand_good(); f[3].spa = 32'd0;
        for (int i = 0; i < 4; i++) begin
            send_frame(f[i], 2, -1);
            tick();
            n_vec++; if (bus.arp_wr_req !== 1'b0) begin n_err++; $display("FAIL nonmatch_%0d got req=%0b exp 0", i, bus.arp_wr_req); end
        end
        n_vec++; if (num_learned !== 32'd0 || num_dropped !== 32'd0) begin n_err++; $display("FAIL nonmatch_cnt got %0d/%0d exp 0/0", num_learned, num_dropped); end
    endtask

    task automatic test_short_disabled_reset();
        do_reset();
        learn_en = 1'b1;
        send_frame(rand_good(), 1, 2);
        tick();
        n_vec++; if (bus.arp_wr_req !== 1'b0) begin n_err++; $display("FAIL short got req=%0b exp 0", bus.arp_wr_req); end
        learn_en = 1'b0;
        send_frame(rand_good(), 1, -1);
        tick();
        n_vec++; if (bus.arp_wr_req !== 1'b0) begin n_err++; $display("FAIL learn_dis got req=%0b exp 0", bus.arp_wr_req); end
        learn_en = 1'b1;
        send_frame(rand_good(), 0, -1);
        pulse_ack();
        send_frame(rand_good(), 0, -1);
        learn_en = 1'b0;
        tick();
        n_vec++; if (bus.arp_wr_req !== 1'b1 || bus.arp_wr_addr !== 5'd17) begin n_err++; $display("FAIL pend_hold got req=%0b addr=%0d exp 1/17", bus.arp_wr_req, bus.arp_wr_addr); end
        reset = 1'b1;
        tick();
        reset = 1'b0;
        m_pending = 1'b0; m_learned = 0; m_dropped = 0;
        n_vec++; if (bus.arp_wr_req !== 1'b0 || bus.arp_wr_addr !== 5'd16 || num_learned !== 32'd0 || num_dropped !== 32'd0) begin n_err++; $display("FAIL mid_reset got req=%0b addr=%0d cnt=%0d/%0d exp 0/16/0/0", bus.arp_wr_req, bus.arp_wr_addr, num_learned, num_dropped); end
    endtask

    task automatic test_random();
        arp_fields_t f;
        do_reset();
        for (int it = 0; it < 60; it++) begin
            f = rand_good();
            if ($urandom_range(9, 0) < 4) begin
                case ($urandom_range(7, 0))
                    0: f.ethertype = 16'h86DD;
                    1: f.htype = 16'd6;
                    2: f.ptype = 16'h86DD;
                    3: f.hlen = 8'd8;
                    4: f.plen = 8'd16;
                    5: f.oper = 16'd1;
                    6: f.spa = 32'd0;
                    default: f.sha[40] = 1'b1;
                endcase
            end
            learn_en = ($urandom_range(9, 0) != 0);
            send_frame(f, 3, -1);
            n_vec++; if (bus.arp_wr_req !== m_pending) begin n_err++; $display("FAIL rnd_req_%0d got %0b exp %0b", it, bus.arp_wr_req, m_pending); end
            if (m_pending) begin
                n_vec++; if (bus.arp_wr_mac !== m_mac || bus.arp_wr_ip !== m_ip || bus.arp_wr_addr !== exp_addr(m_learned)) begin n_err++; $display("FAIL rnd_data_%0d got %h/%h/%0d exp %h/%h/%0d", it, bus.arp_wr_mac, bus.arp_wr_ip, bus.arp_wr_addr, m_mac, m_ip, exp_addr(m_learned)); end
            end
            if ($urandom_range(1, 0) == 1) begin
                repeat ($urandom_range(3, 0)) tick();
                pulse_ack();
            end
            n_vec++; if (num_learned !== 32'(m_learned) || num_dropped !== 32'(m_dropped) || bus.arp_wr_addr !== exp_addr(m_learned)) begin n_err++; $display("FAIL rnd_cnt_%0d got %0d/%0d/%0d exp %0d/%0d/%0d", it, num_learned, num_dropped, bus.arp_wr_addr, m_learned, m_dropped, exp_addr(m_learned)); end
        end
    endtask

    initial begin
        reset = 1'b1; learn_en = 1'b0;
        bus.in_data = '0; bus.in_ctrl = '0; bus.in_wr = 1'b0; bus.arp_wr_ack = 1'b0;
        test_reset();
        test_single(0, "single");
        test_back_to_back();
        test_drop();
        test_nonmatch();
        test_short_disabled_reset();
        test_single(5, "gaps");
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
